// File: rtl/bsc_axiu_axis_packet_arbiter.sv
// rtl/bsc_axiu_axis_packet_arbiter.sv - two-source AXIS packet arbiter with registered output
// Optional build macro: BSC_AXIU_ARB_FIXED_PRIORITY_EN (S0 always preferred in IDLE).
module bsc_axiu_axis_packet_arbiter #(
    parameter int ID_WIDTH = 1
) (
    input  logic                clk,
    input  logic                aresetn,
    input  logic [63:0]         S0_AXIS_tdata,
    input  logic [1:0]          S0_AXIS_tdest,
    input  logic [ID_WIDTH-1:0] S0_AXIS_tid,
    input  logic                S0_AXIS_tlast,
    input  logic                S0_AXIS_tvalid,
    output logic                S0_AXIS_tready,
    input  logic [63:0]         S1_AXIS_tdata,
    input  logic [1:0]          S1_AXIS_tdest,
    input  logic [ID_WIDTH-1:0] S1_AXIS_tid,
    input  logic                S1_AXIS_tlast,
    input  logic                S1_AXIS_tvalid,
    output logic                S1_AXIS_tready,
    output logic [63:0]         M_AXIS_tdata,
    output logic [1:0]          M_AXIS_tdest,
    output logic [ID_WIDTH-1:0] M_AXIS_tid,
    output logic                M_AXIS_tlast,
    output logic                M_AXIS_tvalid,
    input  logic                M_AXIS_tready
);

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t              state, state_nxt;
    logic                grant, grant_nxt;
    logic                pick;
    logic                out_free;
    logic                accept;
    logic [63:0]         sel_tdata;
    logic [1:0]          sel_tdest;
    logic [ID_WIDTH-1:0] sel_tid;
    logic                sel_tlast;
    logic                sel_tvalid;

`ifdef BSC_AXIU_ARB_FIXED_PRIORITY_EN
    assign pick = !S0_AXIS_tvalid;
`else
    logic rr_ptr;

    // Preferred source wins if it is valid, otherwise the other one is taken.
    assign pick = rr_ptr ? S1_AXIS_tvalid : !S0_AXIS_tvalid;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            rr_ptr <= 1'b0;
        end else if (accept && sel_tlast) begin
            rr_ptr <= ~grant;
        end
    end
`endif

    always_comb begin
        sel_tdata  = grant ? S1_AXIS_tdata  : S0_AXIS_tdata;
        sel_tdest  = grant ? S1_AXIS_tdest  : S0_AXIS_tdest;
        sel_tid    = grant ? S1_AXIS_tid    : S0_AXIS_tid;
        sel_tlast  = grant ? S1_AXIS_tlast  : S0_AXIS_tlast;
        sel_tvalid = grant ? S1_AXIS_tvalid : S0_AXIS_tvalid;
    end

    // Output slot is free when empty or draining this cycle: full throughput.
    assign out_free = !M_AXIS_tvalid || M_AXIS_tready;

    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant;
        S0_AXIS_tready = 1'b0;
        S1_AXIS_tready = 1'b0;
        accept         = 1'b0;
        case (state)
            IDLE: begin
                if (S0_AXIS_tvalid || S1_AXIS_tvalid) begin
                    grant_nxt = pick;
                    state_nxt = LOCK;
                end
            end
            LOCK: begin
                S0_AXIS_tready = !grant && out_free;
                S1_AXIS_tready = grant && out_free;
                accept         = sel_tvalid && out_free;
                if (accept && sel_tlast) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
            grant <= 1'b0;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            M_AXIS_tdata  <= '0;
            M_AXIS_tdest  <= '0;
            M_AXIS_tid    <= '0;
            M_AXIS_tlast  <= 1'b0;
            M_AXIS_tvalid <= 1'b0;
        end else if (accept) begin
            M_AXIS_tdata  <= sel_tdata;
            M_AXIS_tdest  <= sel_tdest;
            M_AXIS_tid    <= sel_tid;
            M_AXIS_tlast  <= sel_tlast;
            M_AXIS_tvalid <= 1'b1;
        end else if (M_AXIS_tready) begin
            M_AXIS_tvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bsc_axiu_axis_packet_arbiter.sv
// tb/tb_bsc_axiu_axis_packet_arbiter.sv - self-checking bench for the AXIS packet arbiter
module tb_bsc_axiu_axis_packet_arbiter;

    localparam int ID_WIDTH = 1;

    typedef struct packed {
        logic [63:0]         data;
        logic [1:0]          dest;
        logic [ID_WIDTH-1:0] id;
        logic                last;
        logic [7:0]          delay;
    } beat_t;

    typedef struct {
        logic [63:0] data;
        logic        last;
        int          cyc;
    } obs_t;

    logic                clk = 1'b0;
    logic                aresetn = 1'b0;
    logic [63:0]         s_tdata[2];
    logic [1:0]          s_tdest[2];
    logic [ID_WIDTH-1:0] s_tid[2];
    logic                s_tlast[2];
    logic                s_tvalid[2];
    logic                s_tready[2];
    logic [63:0]         m_tdata;
    logic [1:0]          m_tdest;
    logic [ID_WIDTH-1:0] m_tid;
    logic                m_tlast;
    logic                m_tvalid;
    logic                m_tready = 1'b1;

    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    int    ready_pct = 100;
    bit    rdy_pat[$];
    beat_t sq[2][$];
    beat_t acc[2][$];
    int    start_q[$];
    int    out_src_log[$];
    obs_t  out_log[$];
    bit    fire[2];
    bit    open_in[2];
    bit    prev_v[2];
    bit    dec_v[2];
    int    vrise_cyc[2];
    int    first_acc_cyc[2];
    int    acc_last_cyc[2];

    bsc_axiu_axis_packet_arbiter #(.ID_WIDTH(ID_WIDTH)) dut (
        .clk            (clk),
        .aresetn        (aresetn),
        .S0_AXIS_tdata  (s_tdata[0]),
        .S0_AXIS_tdest  (s_tdest[0]),
        .S0_AXIS_tid    (s_tid[0]),
        .S0_AXIS_tlast  (s_tlast[0]),
        .S0_AXIS_tvalid (s_tvalid[0]),
        .S0_AXIS_tready (s_tready[0]),
        .S1_AXIS_tdata  (s_tdata[1]),
        .S1_AXIS_tdest  (s_tdest[1]),
        .S1_AXIS_tid    (s_tid[1]),
        .S1_AXIS_tlast  (s_tlast[1]),
        .S1_AXIS_tvalid (s_tvalid[1]),
        .S1_AXIS_tready (s_tready[1]),
        .M_AXIS_tdata   (m_tdata),
        .M_AXIS_tdest   (m_tdest),
        .M_AXIS_tid     (m_tid),
        .M_AXIS_tlast   (m_tlast),
        .M_AXIS_tvalid  (m_tvalid),
        .M_AXIS_tready  (m_tready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Source driver: presents queued beats after their idle delay, junk otherwise.
    task automatic drive_src(input int s);
        bit pres = 0;
        bit loaded = 0;
        int wc = 0;
        forever begin
            @(posedge clk);
            if (fire[s] && sq[s].size() > 0) begin
                void'(sq[s].pop_front());
                pres = 0;
                loaded = 0;
            end
            #1;
            if (sq[s].size() == 0) begin
                pres = 0;
                loaded = 0;
            end else if (!pres) begin
                if (!loaded) begin
                    wc = int'(sq[s][0].delay);
                    loaded = 1;
                end
                if (wc == 0) pres = 1;
                else wc--;
            end
            s_tvalid[s] = pres;
            if (pres) begin
                s_tdata[s] = sq[s][0].data;
                s_tdest[s] = sq[s][0].dest;
                s_tid[s]   = sq[s][0].id;
                s_tlast[s] = sq[s][0].last;
            end else begin
                s_tdata[s] = {$urandom, $urandom};
                s_tdest[s] = 2'($urandom);
                s_tid[s]   = ID_WIDTH'($urandom);
                s_tlast[s] = 1'($urandom);
            end
        end
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            s_tvalid[s] = 0; s_tdata[s] = '0; s_tdest[s] = '0; s_tid[s] = '0; s_tlast[s] = 0;
        end
        fork
            drive_src(0);
            drive_src(1);
        join_none
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_pat.size() > 0) m_tready = rdy_pat.pop_front();
            else m_tready = ($urandom_range(99) < ready_pct);
        end
    end

    // Reference model: packets leave in acceptance order, whole, in the arbitration order.
    initial begin : monitor
        bit   idle_m;
        int   last_served;
        bit   out_open;
        int   out_src;
        bit   prev_stall;
        logic [68+ID_WIDTH-1:0] prev_m;
        int   exp_src;
        beat_t b;
        obs_t  o;
        idle_m = 1; last_served = 1; out_open = 0; out_src = 0; prev_stall = 0; prev_m = '0;
        forever begin
            @(negedge clk);
            if (!aresetn) begin
                acc[0].delete(); acc[1].delete(); start_q.delete();
                open_in[0] = 0; open_in[1] = 0; fire[0] = 0; fire[1] = 0;
                out_open = 0; idle_m = 1; last_served = 1; prev_stall = 0;
                prev_v[0] = s_tvalid[0]; prev_v[1] = s_tvalid[1];
            end else begin
                for (int s = 0; s < 2; s++) begin
                    fire[s] = s_tvalid[s] && s_tready[s];
                    if (s_tvalid[s] && !prev_v[s]) vrise_cyc[s] = cyc;
                end
                total++;
                if (s_tready[0] && s_tready[1]) begin
                    bad++;
                    $display("FAIL tready_exclusive: s0=%0b s1=%0b, required at most one", s_tready[0], s_tready[1]);
                end
                for (int s = 0; s < 2; s++) begin
                    if (open_in[1-s]) begin
                        total++;
                        if (s_tready[s] !== 1'b0) begin
                            bad++;
                            $display("FAIL tready_nongranted: s%0d tready=%0b during other packet, required 0", s, s_tready[s]);
                        end
                    end
                end
                if (prev_stall) begin
                    total++;
                    if ({m_tdata, m_tdest, m_tid, m_tlast, m_tvalid} !== prev_m) begin
                        bad++;
                        $display("FAIL out_stable: got %h, required %h", {m_tdata, m_tdest, m_tid, m_tlast, m_tvalid}, prev_m);
                    end
                end
                if (idle_m && (s_tvalid[0] || s_tvalid[1])) begin
                    dec_v[0] = s_tvalid[0];
                    dec_v[1] = s_tvalid[1];
                    idle_m = 0;
                end
                for (int s = 0; s < 2; s++) begin
                    if (fire[s]) begin
                        if (!open_in[s]) begin
`ifdef BSC_AXIU_ARB_FIXED_PRIORITY_EN
                            exp_src = dec_v[0] ? 0 : 1;
`else
                            exp_src = (dec_v[0] && dec_v[1]) ? 1 - last_served : (dec_v[0] ? 0 : 1);
`endif
                            total++;
                            if (s != exp_src) begin
                                bad++;
                                $display("FAIL arbitration: granted s%0d, required s%0d", s, exp_src);
                            end
                            start_q.push_back(s);
                            open_in[s] = 1;
                            first_acc_cyc[s] = cyc;
                        end
                        b.data = s_tdata[s]; b.dest = s_tdest[s]; b.id = s_tid[s];
                        b.last = s_tlast[s]; b.delay = '0;
                        acc[s].push_back(b);
                        if (s_tlast[s]) begin
                            open_in[s] = 0;
                            last_served = s;
                            idle_m = 1;
                            acc_last_cyc[s] = cyc;
                        end
                    end
                end
                if (m_tvalid && m_tready) begin
                    if (!out_open) begin
                        if (start_q.size() == 0) begin
                            total++; bad++;
                            $display("FAIL out_unexpected: beat %h with no packet accepted, required none", m_tdata);
                        end else begin
                            out_src = start_q.pop_front();
                            out_open = 1;
                            out_src_log.push_back(out_src);
                        end
                    end
                    if (out_open) begin
                        total++;
                        if (acc[out_src].size() == 0) begin
                            bad++;
                            $display("FAIL out_extra: beat %h from s%0d, required no beat", m_tdata, out_src);
                        end else begin
                            b = acc[out_src].pop_front();
                            if ({m_tdata, m_tdest, m_tid, m_tlast} !== {b.data, b.dest, b.id, b.last}) begin
                                bad++;
                                $display("FAIL out_beat: got %h/%0d/%0d/%0b, required %h/%0d/%0d/%0b",
                                         m_tdata, m_tdest, m_tid, m_tlast, b.data, b.dest, b.id, b.last);
                            end
                        end
                        out_open = !m_tlast;
                    end
                    o.data = m_tdata; o.last = m_tlast; o.cyc = cyc;
                    out_log.push_back(o);
                end
                prev_stall = m_tvalid && !m_tready;
                prev_m = {m_tdata, m_tdest, m_tid, m_tlast, m_tvalid};
                prev_v[0] = s_tvalid[0];
                prev_v[1] = s_tvalid[1];
            end
        end
    end

    task automatic push_pkt(input int s, input int len, input logic [63:0] base, input logic [1:0] dest,
                            input logic [ID_WIDTH-1:0] id, input int d_first, input int d_rest_max);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data  = base + 64'(i);
            b.dest  = dest;
            b.id    = id;
            b.last  = (i == len - 1);
            b.delay = 8'((i == 0) ? d_first : $urandom_range(d_rest_max));
            sq[s].push_back(b);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 aresetn = 0;
        sq[0].delete(); sq[1].delete(); rdy_pat.delete();
        repeat (2) @(posedge clk);
        #1 aresetn = 1;
    endtask

    task automatic clear_logs();
        out_log.delete();
        out_src_log.delete();
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((sq[0].size() > 0 || sq[1].size() > 0 || acc[0].size() > 0 || acc[1].size() > 0 ||
                start_q.size() > 0 || m_tvalid) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        total++;
        if (n >= 3000) begin
            bad++;
            $display("FAIL %s_drain: timeout after %0d cycles, required drained", name, n);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        int n = 0;
        ready_pct = 100;
        do_reset();
        push_pkt(0, 4, 64'h100, 2'd1, 1'b0, 0, 0);
        while (!m_tvalid && n < 50) begin @(negedge clk); n++; end
        total++;
        if (!m_tvalid) begin bad++; $display("FAIL reset_pre: m_tvalid=%0b, required 1", m_tvalid); end
        @(posedge clk);
        #2 aresetn = 0;
        sq[0].delete(); sq[1].delete();
        #1;
        total++;
        if ({m_tdata, m_tdest, m_tid, m_tlast, m_tvalid} !== '0) begin
            bad++;
            $display("FAIL reset_m_out: got %h, required 0", {m_tdata, m_tdest, m_tid, m_tlast, m_tvalid});
        end
        total++;
        if (s_tready[0] !== 1'b0 || s_tready[1] !== 1'b0) begin
            bad++;
            $display("FAIL reset_tready: got %0b%0b, required 00", s_tready[0], s_tready[1]);
        end
        repeat (2) @(posedge clk);
        #1 aresetn = 1;
        clear_logs();
        push_pkt(1, 3, 64'h200, 2'd3, 1'b1, 0, 0);
        wait_drain("reset");
        total++;
        if (out_log.size() != 3 || out_src_log.size() != 1) begin
            bad++;
            $display("FAIL reset_after: got %0d beats %0d pkts, required 3 beats 1 pkt", out_log.size(), out_src_log.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if (out_log[i].data !== 64'h200 + 64'(i)) begin
                    bad++;
                    $display("FAIL reset_after_data: got %h, required %h", out_log[i].data, 64'h200 + 64'(i));
                end
            end
        end
    endtask

    task automatic test_single_source();
        ready_pct = 100;
        clear_logs();
        push_pkt(0, 4, 64'h1, 2'd2, 1'b1, 0, 0);
        wait_drain("single");
        total++;
        if (out_log.size() != 4) begin
            bad++;
            $display("FAIL single_count: got %0d, required 4", out_log.size());
        end else begin
            total++;
            if (out_log[0].cyc - vrise_cyc[0] != 2) begin
                bad++;
                $display("FAIL single_latency: got %0d, required 2", out_log[0].cyc - vrise_cyc[0]);
            end
            for (int i = 0; i < 4; i++) begin
                total++;
                if (out_log[i].data !== 64'(i + 1) || out_log[i].last !== (i == 3) || out_log[i].cyc != out_log[0].cyc + i) begin
                    bad++;
                    $display("FAIL single_beat%0d: got %h last=%0b cyc+%0d, required %h last=%0b cyc+%0d", i,
                             out_log[i].data, out_log[i].last, out_log[i].cyc - out_log[0].cyc, 64'(i + 1), (i == 3), i);
                end
            end
        end
    endtask

    task automatic test_contention();
        int exp;
        ready_pct = 100;
        do_reset();
        clear_logs();
        for (int p = 0; p < 4; p++) begin
            push_pkt(0, 3, 64'h1000 + 64'(p * 16), 2'd0, 1'b0, 0, 0);
            push_pkt(1, 3, 64'h2000 + 64'(p * 16), 2'd1, 1'b1, 0, 0);
        end
        wait_drain("contention");
        total++;
        if (out_src_log.size() != 8) begin
            bad++;
            $display("FAIL contention_pkts: got %0d, required 8", out_src_log.size());
        end else begin
            for (int p = 0; p < 8; p++) begin
`ifdef BSC_AXIU_ARB_FIXED_PRIORITY_EN
                exp = (p < 4) ? 0 : 1;
`else
                exp = p % 2;
`endif
                total++;
                if (out_src_log[p] != exp) begin
                    bad++;
                    $display("FAIL contention_order%0d: got s%0d, required s%0d", p, out_src_log[p], exp);
                end
            end
        end
        for (int i = 1; i < out_log.size(); i++) begin
            total++;
            if (out_log[i].cyc - out_log[i-1].cyc != (out_log[i-1].last ? 2 : 1)) begin
                bad++;
                $display("FAIL contention_gap%0d: got %0d, required %0d", i,
                         out_log[i].cyc - out_log[i-1].cyc, out_log[i-1].last ? 2 : 1);
            end
        end
    endtask

    task automatic test_backpressure();
        int n = 0;
        ready_pct = 100;
        clear_logs();
        push_pkt(0, 5, 64'h5000, 2'd2, 1'b0, 0, 0);
        while (!m_tvalid && n < 50) begin @(negedge clk); n++; end
        rdy_pat.push_back(1); rdy_pat.push_back(0); rdy_pat.push_back(0); rdy_pat.push_back(1);
        rdy_pat.push_back(0); rdy_pat.push_back(1);
        wait_drain("backpressure");
        total++;
        if (out_log.size() != 5) begin
            bad++;
            $display("FAIL bp_count: got %0d, required 5", out_log.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                total++;
                if (out_log[i].data !== 64'h5000 + 64'(i)) begin
                    bad++;
                    $display("FAIL bp_data%0d: got %h, required %h", i, out_log[i].data, 64'h5000 + 64'(i));
                end
            end
        end
    endtask

    task automatic test_single_beat();
        ready_pct = 100;
        clear_logs();
        push_pkt(1, 1, 64'hA, 2'd1, 1'b1, 0, 0);
        push_pkt(1, 1, 64'hB, 2'd1, 1'b1, 0, 0);
        wait_drain("single_beat");
        total++;
        if (out_log.size() != 2) begin
            bad++;
            $display("FAIL sb_count: got %0d, required 2", out_log.size());
        end else begin
            total++;
            if (out_log[0].data !== 64'hA || out_log[1].data !== 64'hB || !out_log[0].last || !out_log[1].last) begin
                bad++;
                $display("FAIL sb_beats: got %h/%0b %h/%0b, required a/1 b/1",
                         out_log[0].data, out_log[0].last, out_log[1].data, out_log[1].last);
            end
            total++;
            if (out_log[1].cyc - out_log[0].cyc != 2) begin
                bad++;
                $display("FAIL sb_bubble: got gap %0d, required 2", out_log[1].cyc - out_log[0].cyc);
            end
        end
    endtask

    task automatic test_source_stall();
        beat_t b;
        ready_pct = 100;
        do_reset();
        clear_logs();
        for (int i = 0; i < 4; i++) begin
            b.data = 64'h6000 + 64'(i); b.dest = 2'd0; b.id = 1'b0; b.last = (i == 3);
            b.delay = (i == 2) ? 8'd3 : 8'd0;
            sq[0].push_back(b);
        end
        push_pkt(1, 2, 64'h7000, 2'd3, 1'b1, 1, 0);
        wait_drain("stall");
        total++;
        if (first_acc_cyc[1] <= acc_last_cyc[0]) begin
            bad++;
            $display("FAIL stall_order: s1 first accept cyc %0d, required after %0d", first_acc_cyc[1], acc_last_cyc[0]);
        end
        total++;
        if (out_src_log.size() != 2 || out_src_log[0] != 0) begin
            bad++;
            $display("FAIL stall_pkts: got %0d pkts, required 2 starting with s0", out_src_log.size());
        end
    endtask

    task automatic test_random();
        int npk;
        for (int r = 0; r < 4; r++) begin
            ready_pct = 40 + $urandom_range(60);
            clear_logs();
            npk = 0;
            for (int p = 0; p < 3; p++) begin
                for (int s = 0; s < 2; s++) begin
                    push_pkt(s, 1 + $urandom_range(4), {$urandom, $urandom}, 2'($urandom),
                             ID_WIDTH'($urandom), $urandom_range(2), 2);
                    npk++;
                end
            end
            wait_drain("random");
            total++;
            if (out_src_log.size() != npk) begin
                bad++;
                $display("FAIL random_pkts: got %0d, required %0d", out_src_log.size(), npk);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_source();
        test_contention();
        test_backpressure();
        test_single_beat();
        test_source_stall();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
